// File: rtl/br_predict_pkg.sv
// Shared types, defaults and helpers for the br_predict fetch-side branch predictor.
// Optional statistics counters are enabled with the BR_STATS_EN macro (see br_predict.sv).
package br_predict_pkg;

    localparam int unsigned BTB_ENTRIES_DEF = 16;
    localparam int unsigned PC_SZ_DEF       = 32;
    localparam int unsigned BR_KIND_W       = 2;
    localparam int unsigned CNTR_W          = 2;

    localparam logic [CNTR_W-1:0] CNTR_RESET      = 2'b01;
    localparam logic [CNTR_W-1:0] CNTR_ALLOC_COND = 2'b10;
    localparam logic [CNTR_W-1:0] CNTR_ALLOC_JUMP = 2'b11;

    typedef enum logic [BR_KIND_W-1:0] {
        BK_COND = 2'd0,
        BK_JAL  = 2'd1,
        BK_JALR = 2'd2,
        BK_XRET = 2'd3
    } br_kind_e;

    // 2-bit saturating counter step; never wraps at either end
    function automatic logic [CNTR_W-1:0] sat_cntr_update(input logic [CNTR_W-1:0] cntr,
                                                          input logic              taken);
        logic [CNTR_W-1:0] nxt;
        nxt = cntr;
        if (taken && (cntr != 2'b11)) begin
            nxt = cntr + 2'b01;
        end else if (!taken && (cntr != 2'b00)) begin
            nxt = cntr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/br_predict_if.sv
// Fetch lookup, EXE resolution and redirect signals of the branch predictor.
interface br_predict_if
    import br_predict_pkg::*;
#(
    parameter int unsigned PC_SZ = PC_SZ_DEF
);

    logic                 fet_valid;
    logic [PC_SZ-1:0]     fet_pc;
    logic                 pred_taken;
    logic [PC_SZ-1:0]     pred_pc;

    logic                 upd_valid;
    logic [BR_KIND_W-1:0] upd_kind;
    logic [PC_SZ-1:0]     upd_pc;
    logic                 upd_taken;
    logic [PC_SZ-1:0]     upd_br_pc;
    logic [PC_SZ-1:0]     upd_no_br_pc;
    logic                 upd_pred_taken;
    logic [PC_SZ-1:0]     upd_pred_pc;

    logic                 redirect_valid;
    logic [PC_SZ-1:0]     redirect_pc;

    modport master (
        output fet_valid, fet_pc,
        output upd_valid, upd_kind, upd_pc, upd_taken, upd_br_pc, upd_no_br_pc,
        output upd_pred_taken, upd_pred_pc,
        input  pred_taken, pred_pc, redirect_valid, redirect_pc
    );

    modport slave (
        input  fet_valid, fet_pc,
        input  upd_valid, upd_kind, upd_pc, upd_taken, upd_br_pc, upd_no_br_pc,
        input  upd_pred_taken, upd_pred_pc,
        output pred_taken, pred_pc, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/br_predict_btb_array.sv
// Direct-mapped BTB register file: two combinational read ports (fetch lookup and
// update read-modify-write), one synchronous write port, synchronous reset clear.
module br_predict_btb_array
    import br_predict_pkg::*;
#(
    parameter int unsigned ENTRIES = BTB_ENTRIES_DEF,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TAG_W   = 27,
    parameter int unsigned TGT_W   = 31
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [TGT_W-1:0]  rd_target,
    output logic [CNTR_W-1:0] rd_cntr,

    input  logic [IDX_W-1:0]  rd2_idx,
    output logic              rd2_valid,
    output logic [TAG_W-1:0]  rd2_tag,
    output logic [TGT_W-1:0]  rd2_target,
    output logic [CNTR_W-1:0] rd2_cntr,

    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [TGT_W-1:0]  wr_target,
    input  logic [CNTR_W-1:0] wr_cntr
);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [TGT_W-1:0]  target;
        logic [CNTR_W-1:0] cntr;
    } btb_entry_t;

    btb_entry_t mem [ENTRIES];

    // Storage: reset invalidates every entry and parks counters weakly not-taken
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem[IDX_W'(i)].valid  <= 1'b0;
                mem[IDX_W'(i)].tag    <= '0;
                mem[IDX_W'(i)].target <= '0;
                mem[IDX_W'(i)].cntr   <= CNTR_RESET;
            end
        end else if (wr_en) begin
            mem[wr_idx].valid  <= 1'b1;
            mem[wr_idx].tag    <= wr_tag;
            mem[wr_idx].target <= wr_target;
            mem[wr_idx].cntr   <= wr_cntr;
        end
    end

    assign rd_valid   = mem[rd_idx].valid;
    assign rd_tag     = mem[rd_idx].tag;
    assign rd_target  = mem[rd_idx].target;
    assign rd_cntr    = mem[rd_idx].cntr;

    assign rd2_valid  = mem[rd2_idx].valid;
    assign rd2_tag    = mem[rd2_idx].tag;
    assign rd2_target = mem[rd2_idx].target;
    assign rd2_cntr   = mem[rd2_idx].cntr;

endmodule

// File: rtl/br_predict.sv
// Fetch-side BTB branch predictor with EXE-side training and registered mispredict redirect.
// Define BR_STATS_EN to add the br_cnt / mp_cnt statistics outputs.
module br_predict
    import br_predict_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int unsigned PC_SZ       = PC_SZ_DEF
) (
    input  logic        clk_in,
    input  logic        reset_in,
    br_predict_if.slave bp
`ifdef BR_STATS_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] mp_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = PC_SZ - IDX_W - 1;
    localparam int unsigned TGT_W = PC_SZ - 1;

    if ((BTB_ENTRIES < 2) || ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)) begin : g_bad_cfg
        $error("br_predict: BTB_ENTRIES must be a power of 2 and at least 2");
    end

    logic [IDX_W-1:0]  fet_idx;
    logic [TAG_W-1:0]  fet_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [TGT_W-1:0]  rd_target;
    logic [CNTR_W-1:0] rd_cntr;
    logic              hit;

    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              u_valid;
    logic [TAG_W-1:0]  u_tag;
    logic [TGT_W-1:0]  u_target;
    logic [CNTR_W-1:0] u_cntr;
    logic              upd_hit;
    br_kind_e          kind;

    logic              wr_en;
    logic [TGT_W-1:0]  wr_target;
    logic [CNTR_W-1:0] wr_cntr;

    logic              mp;
    logic [PC_SZ-1:0]  nxt_redirect_pc;
    logic              unused_upd_pc_lsb;

    // Halfword-granular indexing so compressed instructions get their own entries
    assign fet_idx = bp.fet_pc[IDX_W:1];
    assign fet_tag = bp.fet_pc[PC_SZ-1:IDX_W+1];
    assign upd_idx = bp.upd_pc[IDX_W:1];
    assign upd_tag = bp.upd_pc[PC_SZ-1:IDX_W+1];
    assign kind    = br_kind_e'(bp.upd_kind);

    assign unused_upd_pc_lsb = bp.upd_pc[0];

    br_predict_btb_array #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .TGT_W   (TGT_W)
    ) u_btb (
        .clk        (clk_in),
        .rst        (reset_in),
        .rd_idx     (fet_idx),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_cntr    (rd_cntr),
        .rd2_idx    (upd_idx),
        .rd2_valid  (u_valid),
        .rd2_tag    (u_tag),
        .rd2_target (u_target),
        .rd2_cntr   (u_cntr),
        .wr_en      (wr_en),
        .wr_idx     (upd_idx),
        .wr_tag     (upd_tag),
        .wr_target  (wr_target),
        .wr_cntr    (wr_cntr)
    );

    // Lookup reads the registered table only, so a same-cycle update is not bypassed
    assign hit           = bp.fet_valid & rd_valid & (rd_tag == fet_tag);
    assign bp.pred_taken = hit & rd_cntr[1];
    assign bp.pred_pc    = bp.pred_taken ? {rd_target, 1'b0} : bp.fet_pc;

    assign upd_hit = u_valid & (u_tag == upd_tag);

    // Training: conditional branches step the counter, jumps install strongly taken
    always_comb begin
        wr_en     = 1'b0;
        wr_target = bp.upd_br_pc[PC_SZ-1:1];
        wr_cntr   = u_cntr;
        if (bp.upd_valid) begin
            case (kind)
                BK_COND: begin
                    if (upd_hit) begin
                        wr_en   = 1'b1;
                        wr_cntr = sat_cntr_update(u_cntr, bp.upd_taken);
                        if (!bp.upd_taken) begin
                            wr_target = u_target;
                        end
                    end else if (bp.upd_taken) begin
                        wr_en   = 1'b1;
                        wr_cntr = CNTR_ALLOC_COND;
                    end
                end
                BK_JAL, BK_JALR: begin
                    wr_en   = 1'b1;
                    wr_cntr = CNTR_ALLOC_JUMP;
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
    end

    assign mp = bp.upd_valid &
                ((bp.upd_taken != bp.upd_pred_taken) |
                 (bp.upd_taken & (bp.upd_br_pc != bp.upd_pred_pc)));

    assign nxt_redirect_pc = bp.upd_taken ? bp.upd_br_pc : bp.upd_no_br_pc;

    // Redirect register: one pulse per mispredicting resolution
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            bp.redirect_valid <= 1'b0;
            bp.redirect_pc    <= '0;
        end else begin
            bp.redirect_valid <= mp;
            bp.redirect_pc    <= nxt_redirect_pc;
        end
    end

`ifdef BR_STATS_EN
    // Free-running statistics; wrap naturally at 2^32
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (bp.upd_valid) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (mp) begin
                mp_cnt <= mp_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
